// File: rtl/uart_echo_bridge.sv
// UART rx->tx echo bridge: FIFO-buffered words, selectable transform, busy-handshaked
// transmit launch, plus rx/drop counters and a heartbeat LED divider.
module uart_echo_bridge #(
  parameter int DW      = 8,
  parameter int AW      = 4,
  parameter int CNT_W   = 16,
  parameter int HB_DIV  = 12_500_000,
  parameter int BUSY_TO = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [DW-1:0]    i_rx_dat,
  input  logic             i_rx_rdy,
  input  logic             i_tx_busy,
  input  logic [1:0]       i_mode,
  output logic [DW-1:0]    o_tx_dat,
  output logic             o_tx_en,
  output logic [AW:0]      o_fifo_level,
  output logic             o_overflow,
  output logic [CNT_W-1:0] o_rx_cnt,
  output logic [CNT_W-1:0] o_drop_cnt,
  output logic             o_hb_led
);

  // state     | meaning
  // S_IDLE    | wait for a queued word and an idle transmitter, then pop
  // S_LAUNCH  | transformed word registered; tx_en rises on leaving
  // S_WAIT_HI | tx_en cycle onward; wait up to BUSY_TO cycles for tx_busy
  // S_WAIT_LO | frame on the line; wait for tx_busy to drop

  localparam int DEPTH = 1 << AW;
  localparam int HB_W  = $clog2(HB_DIV);
  localparam int TO_W  = $clog2(BUSY_TO + 1);

  localparam logic [1:0] M_UPPER  = 2'b01;
  localparam logic [1:0] M_INVERT = 2'b10;
  localparam logic [1:0] M_MUTE   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_HI, S_WAIT_LO} state_t;

  state_t           r_state;
  logic [DW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic [TO_W-1:0]  r_to_cnt;
  logic [HB_W-1:0]  r_hb_cnt;
  logic             r_hb_led;
  logic [DW-1:0]    r_tx_dat;
  logic             r_tx_en;
  logic             r_overflow;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_pop;
  logic             w_full;
  logic             w_wr;
  logic             w_drop;
  logic [DW-1:0]    w_head;
  logic [DW-1:0]    w_xform;

  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign w_pop  = (r_state == S_IDLE) && (r_level != '0) && !i_tx_busy;
  assign w_full = (r_level == (AW+1)'(DEPTH));
  assign w_wr   = i_rx_rdy && (!w_full || w_pop);
  assign w_drop = i_rx_rdy && !w_wr;
  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    w_xform = w_head;
    case (i_mode)
      M_UPPER: begin
        if ((w_head >= DW'(8'h61)) && (w_head <= DW'(8'h7A)))
          w_xform = w_head - DW'(8'h20);
      end
      M_INVERT: w_xform = ~w_head;
      default:  w_xform = w_head;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wr)
      r_mem[r_wr_ptr] <= i_rx_dat;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_rx_cnt   <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_pop)
        r_level <= r_level + (AW+1)'(1);
      else if (!w_wr && w_pop)
        r_level <= r_level - (AW+1)'(1);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1)
          r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_tx_dat <= '0;
      r_tx_en  <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      r_tx_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // MUTE consumes the word but leaves tx_dat and the state untouched
          if (w_pop && (i_mode != M_MUTE)) begin
            r_tx_dat <= w_xform;
            r_state  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_tx_en  <= 1'b1;
          r_to_cnt <= TO_W'(BUSY_TO);
          r_state  <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (i_tx_busy)
            r_state <= S_WAIT_LO;
          else if (r_to_cnt <= TO_W'(1))
            r_state <= S_IDLE;
          else
            r_to_cnt <= r_to_cnt - TO_W'(1);
        end
        S_WAIT_LO: begin
          if (!i_tx_busy)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hb_cnt <= HB_W'(HB_DIV - 1);
      r_hb_led <= 1'b1;
    end else if (r_hb_cnt == '0) begin
      r_hb_cnt <= HB_W'(HB_DIV - 1);
      r_hb_led <= ~r_hb_led;
    end else begin
      r_hb_cnt <= r_hb_cnt - HB_W'(1);
    end
  end

  assign o_tx_dat     = r_tx_dat;
  assign o_tx_en      = r_tx_en;
  assign o_fifo_level = r_level;
  assign o_overflow   = r_overflow;
  assign o_rx_cnt     = r_rx_cnt;
  assign o_drop_cnt   = r_drop_cnt;
  assign o_hb_led     = r_hb_led;

endmodule

// File: tb/tb_uart_echo_bridge.sv
// Scoreboard bench for uart_echo_bridge: small FIFO, 4-bit counters and a short
// heartbeat so wrap, saturation and LED toggling are all reachable quickly.
module tb_uart_echo_bridge;

  localparam int DW      = 8;
  localparam int AW      = 2;
  localparam int CNT_W   = 4;
  localparam int HB_DIV  = 4;
  localparam int BUSY_TO = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    rx_dat;
  logic             rx_rdy;
  logic             tx_busy;
  logic [1:0]       mode;
  logic [DW-1:0]    tx_dat;
  logic             tx_en;
  logic [AW:0]      fifo_level;
  logic             overflow;
  logic [CNT_W-1:0] rx_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             hb_led;

  logic force_busy = 1'b0;
  logic resp_busy  = 1'b0;
  logic resp_en    = 1'b0;
  logic resp_active = 1'b0;
  int   resp_delay = 10;
  int   resp_len   = 5;

  logic [7:0] exp_q[$];
  logic [7:0] rcv_q[$];
  int checks = 0;
  int errors = 0;
  int tx_count = 0;
  int cyc = 0;
  int last_tx_cyc = 0;
  int prev_tx_cyc = 0;
  logic prev_en = 1'b0;
  logic consec_seen = 1'b0;
  logic [CNT_W-1:0] exp_rx = '0;
  logic [CNT_W-1:0] exp_drop = '0;

  assign tx_busy = force_busy | resp_busy;

  uart_echo_bridge #(
    .DW(DW), .AW(AW), .CNT_W(CNT_W), .HB_DIV(HB_DIV), .BUSY_TO(BUSY_TO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_dat(rx_dat), .i_rx_rdy(rx_rdy),
    .i_tx_busy(tx_busy), .i_mode(mode), .o_tx_dat(tx_dat), .o_tx_en(tx_en),
    .o_fifo_level(fifo_level), .o_overflow(overflow), .o_rx_cnt(rx_cnt),
    .o_drop_cnt(drop_cnt), .o_hb_led(hb_led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // observed transmissions go to rcv_q for the test tasks to score
  always @(negedge clk) begin
    if (tx_en) begin
      if (prev_en) consec_seen = 1'b1;
      rcv_q.push_back(tx_dat);
      tx_count    = tx_count + 1;
      prev_tx_cyc = last_tx_cyc;
      last_tx_cyc = cyc;
    end
    prev_en = tx_en;
  end

  // transmitter model: busy rises resp_delay cycles after tx_en, lasts resp_len cycles
  initial forever begin
    @(negedge clk);
    if (tx_en && resp_en) begin
      resp_active = 1'b1;
      repeat (resp_delay) @(negedge clk);
      resp_busy = 1'b1;
      repeat (resp_len) @(negedge clk);
      resp_busy = 1'b0;
      resp_active = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit reached, expected end of tests");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [7:0] d);
    rx_dat = d;
    rx_rdy = 1'b1;
    @(negedge clk);
    rx_rdy = 1'b0;
  endtask

  task automatic accept_model();
    exp_rx = exp_rx + 1'b1;
  endtask

  task automatic drop_model();
    if (exp_drop != '1) exp_drop = exp_drop + 1'b1;
  endtask

  task automatic drain(input int max_cyc, output bit ok);
    int stable = 0;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (rcv_q.size() >= exp_q.size() && fifo_level == 0 && !tx_busy && !resp_active)
        stable++;
      else
        stable = 0;
      if (stable >= 4) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_rdy = 1'b0; rx_dat = '0; mode = 2'b00;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_dat, tx_en, fifo_level, overflow, rx_cnt, drop_cnt, hb_led} !==
        {8'h00, 1'b0, 3'd0, 1'b0, 4'd0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values: got tx_dat=%h tx_en=%b lvl=%0d ovf=%b rx=%0d drop=%0d hb=%b, expected 00 0 0 0 0 0 1",
               tx_dat, tx_en, fifo_level, overflow, rx_cnt, drop_cnt, hb_led);
    end
    rst = 1'b0;
    exp_rx = '0; exp_drop = '0;
  endtask

  task automatic test_echo();
    bit ok;
    int base = tx_count;
    mode = 2'b00; resp_en = 1'b1; resp_delay = 10; resp_len = 5;
    exp_q.push_back(8'h41);
    send(8'h41); accept_model();
    @(negedge clk);
    checks++;
    if (tx_en !== 1'b0) begin errors++; $display("FAIL echo_latency_early: got tx_en=%b, expected 0", tx_en); end
    @(negedge clk);
    checks++;
    if (tx_en !== 1'b1) begin errors++; $display("FAIL echo_latency: got tx_en=%b, expected 1", tx_en); end
    drain(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL echo_drain: got timeout, expected idle bridge"); end
    checks++;
    if (tx_count - base != 1) begin errors++; $display("FAIL echo_tx_count: got %0d, expected 1", tx_count - base); end
    while (exp_q.size() > 0 && rcv_q.size() > 0) begin
      logic [7:0] e = exp_q.pop_front();
      logic [7:0] a = rcv_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL echo_data: got %h, expected %h", a, e); end
    end
    checks++;
    if (tx_dat !== 8'h41) begin errors++; $display("FAIL echo_tx_dat_hold: got %h, expected 41", tx_dat); end
    checks++;
    if (rx_cnt !== exp_rx) begin errors++; $display("FAIL echo_rx_cnt: got %0d, expected %0d", rx_cnt, exp_rx); end
    exp_q.delete(); rcv_q.delete();
  endtask

  task automatic test_upper_invert_mute();
    bit ok;
    int base;
    mode = 2'b01;
    exp_q.push_back(8'h41); exp_q.push_back(8'h5A); exp_q.push_back(8'h5B);
    send(8'h61); accept_model();
    send(8'h7A); accept_model();
    send(8'h5B); accept_model();
    drain(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL upper_drain: got timeout, expected idle bridge"); end
    mode = 2'b10;
    exp_q.push_back(8'hF0);
    send(8'h0F); accept_model();
    drain(200, ok);
    checks++;
    if (rcv_q.size() != exp_q.size()) begin
      errors++; $display("FAIL xform_count: got %0d words, expected %0d", rcv_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rcv_q.size() > 0) begin
      logic [7:0] e = exp_q.pop_front();
      logic [7:0] a = rcv_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL xform_data: got %h, expected %h", a, e); end
    end
    exp_q.delete(); rcv_q.delete();
    base = tx_count;
    mode = 2'b11;
    send(8'h33); accept_model();
    drain(100, ok);
    checks++;
    if (tx_count != base) begin errors++; $display("FAIL mute_no_tx: got %0d tx_en, expected 0", tx_count - base); end
    checks++;
    if ({tx_dat, fifo_level, rx_cnt} !== {8'hF0, 3'd0, exp_rx}) begin
      errors++; $display("FAIL mute_state: got tx_dat=%h lvl=%0d rx=%0d, expected F0 0 %0d", tx_dat, fifo_level, rx_cnt, exp_rx);
    end
    rcv_q.delete();
  endtask

  task automatic test_overflow_full_pop();
    bit ok;
    int base = tx_count;
    mode = 2'b00; resp_en = 1'b1; resp_delay = 3; resp_len = 4;
    force_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(8'h10 + 8'(i));
      if (i < 4) begin exp_q.push_back(8'h10 + 8'(i)); accept_model(); end
      else drop_model();
    end
    checks++;
    if ({fifo_level, drop_cnt, overflow, rx_cnt} !== {3'd4, exp_drop, 1'b1, exp_rx}) begin
      errors++; $display("FAIL overflow_state: got lvl=%0d drop=%0d ovf=%b rx=%0d, expected 4 %0d 1 %0d",
                         fifo_level, drop_cnt, overflow, rx_cnt, exp_drop, exp_rx);
    end
    checks++;
    if (tx_count != base) begin errors++; $display("FAIL overflow_held: got %0d tx_en, expected 0", tx_count - base); end
    force_busy = 1'b0;
    exp_q.push_back(8'h16);
    send(8'h16); accept_model();
    checks++;
    if ({fifo_level, drop_cnt, rx_cnt} !== {3'd4, exp_drop, exp_rx}) begin
      errors++; $display("FAIL full_pop: got lvl=%0d drop=%0d rx=%0d, expected 4 %0d %0d", fifo_level, drop_cnt, rx_cnt, exp_drop, exp_rx);
    end
    drain(600, ok);
    checks++;
    if (!ok || rcv_q.size() != 5) begin
      errors++; $display("FAIL overflow_drain: got ok=%b words=%0d, expected 1 5", ok, rcv_q.size());
    end
    while (exp_q.size() > 0 && rcv_q.size() > 0) begin
      logic [7:0] e = exp_q.pop_front();
      logic [7:0] a = rcv_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL overflow_order: got %h, expected %h", a, e); end
    end
    checks++;
    if ({fifo_level, overflow} !== {3'd0, 1'b1}) begin
      errors++; $display("FAIL overflow_sticky: got lvl=%0d ovf=%b, expected 0 1", fifo_level, overflow);
    end
    exp_q.delete(); rcv_q.delete();
  endtask

  task automatic test_drop_saturate();
    bit ok;
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(8'hC0 + 8'(i)); exp_q.push_back(8'hC0 + 8'(i)); accept_model();
    end
    for (int i = 0; i < 14; i++) begin
      send(8'hEE); drop_model();
    end
    checks++;
    if (drop_cnt !== exp_drop) begin errors++; $display("FAIL drop_saturate: got %0d, expected %0d", drop_cnt, exp_drop); end
    checks++;
    if ({fifo_level, rx_cnt} !== {3'd4, exp_rx}) begin
      errors++; $display("FAIL sat_state: got lvl=%0d rx=%0d, expected 4 %0d", fifo_level, rx_cnt, exp_rx);
    end
    force_busy = 1'b0;
    drain(600, ok);
    checks++;
    if (!ok || rcv_q.size() != exp_q.size()) begin
      errors++; $display("FAIL sat_drain: got ok=%b words=%0d, expected 1 %0d", ok, rcv_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rcv_q.size() > 0) begin
      logic [7:0] e = exp_q.pop_front();
      logic [7:0] a = rcv_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL sat_data: got %h, expected %h", a, e); end
    end
    exp_q.delete(); rcv_q.delete();
  endtask

  task automatic test_timeout();
    bit ok = 1'b0;
    int base = tx_count;
    resp_en = 1'b0; mode = 2'b00;
    exp_q.push_back(8'h5A); exp_q.push_back(8'hA5);
    send(8'h5A); accept_model();
    send(8'hA5); accept_model();
    checks++;
    if (rx_cnt !== exp_rx) begin errors++; $display("FAIL rx_cnt_wrap: got %0d, expected %0d", rx_cnt, exp_rx); end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_count >= base + 2) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_second_tx: got %0d tx_en, expected 2", tx_count - base); end
    checks++;
    if (last_tx_cyc - prev_tx_cyc != BUSY_TO + 2) begin
      errors++; $display("FAIL timeout_gap: got %0d cycles, expected %0d", last_tx_cyc - prev_tx_cyc, BUSY_TO + 2);
    end
    repeat (BUSY_TO + 4) @(negedge clk);
    resp_en = 1'b1;
    exp_q.push_back(8'h77);
    send(8'h77); accept_model();
    drain(200, ok);
    checks++;
    if (!ok || rcv_q.size() != 3) begin
      errors++; $display("FAIL timeout_recover: got ok=%b words=%0d, expected 1 3", ok, rcv_q.size());
    end
    while (exp_q.size() > 0 && rcv_q.size() > 0) begin
      logic [7:0] e = exp_q.pop_front();
      logic [7:0] a = rcv_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL timeout_data: got %h, expected %h", a, e); end
    end
    exp_q.delete(); rcv_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic exp_hb;
    mode = 2'b00; resp_en = 1'b1; resp_delay = 2; resp_len = 40;
    for (int i = 0; i < 4; i++) begin
      send(8'h21 + 8'(i)); exp_q.push_back(8'h21 + 8'(i)); accept_model();
    end
    for (int i = 0; i < 50 && !resp_busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if ({fifo_level, rcv_q.size() == 1} !== {3'd3, 1'b1}) begin
      errors++; $display("FAIL pre_reset: got lvl=%0d words=%0d, expected 3 1", fifo_level, rcv_q.size());
    end
    checks++;
    if (rcv_q.size() > 0 && rcv_q[0] !== 8'h21) begin
      errors++; $display("FAIL pre_reset_data: got %h, expected 21", rcv_q[0]);
    end
    rst = 1'b1;
    exp_q.delete(); rcv_q.delete();
    exp_rx = '0; exp_drop = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx_dat, tx_en, fifo_level, overflow, rx_cnt, drop_cnt, hb_led} !==
        {8'h00, 1'b0, 3'd0, 1'b0, 4'd0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset_values: got tx_dat=%h tx_en=%b lvl=%0d ovf=%b rx=%0d drop=%0d hb=%b, expected 00 0 0 0 0 0 1",
               tx_dat, tx_en, fifo_level, overflow, rx_cnt, drop_cnt, hb_led);
    end
    rst = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      exp_hb = ((j / HB_DIV) % 2) == 0;
      checks++;
      if (hb_led !== exp_hb) begin errors++; $display("FAIL hb_led_%0d: got %b, expected %b", j, hb_led, exp_hb); end
    end
    for (int i = 0; i < 80 && resp_active; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    checks++;
    if ({rcv_q.size() == 0, fifo_level, rx_cnt} !== {1'b1, 3'd0, 4'd0}) begin
      errors++; $display("FAIL post_reset_quiet: got words=%0d lvl=%0d rx=%0d, expected 0 0 0", rcv_q.size(), fifo_level, rx_cnt);
    end
    resp_len = 4;
    exp_q.push_back(8'h99);
    send(8'h99); accept_model();
    drain(200, ok);
    checks++;
    if (!ok || rcv_q.size() != 1 || rcv_q[0] !== 8'h99) begin
      errors++; $display("FAIL post_reset_tx: got ok=%b words=%0d, expected 1 word 99", ok, rcv_q.size());
    end
    checks++;
    if (consec_seen) begin errors++; $display("FAIL tx_en_consecutive: got back-to-back tx_en, expected isolated pulses"); end
    exp_q.delete(); rcv_q.delete();
  endtask

  initial begin
    rst = 1'b1; rx_rdy = 1'b0; rx_dat = '0; mode = 2'b00;
    @(negedge clk);
    test_reset();
    test_echo();
    test_upper_invert_mute();
    test_overflow_full_pop();
    test_drop_saturate();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
